sdram_req_arbiter: RTL
======================

Name: sdram_req_arbiter

Overview:
Shares the single SDRAM controller application request port between two clients. The first client is the video read requester (reads). The second is a frame-buffer write client, such as the USB-fed pixel writer, which replaces the boot-time-only init mux. Reads have priority so the video FIFO never starves. A streak counter guarantees writes forward progress. The block also sequences the write data phase by routing next-data strobes to the write client until the burst's last word.

Parameters:
ADDR_W, 25, SDRAM request address width
RD_LEN, 4, burst length (16-bit words) driven for read requests
WR_LEN, 4, burst length driven for write requests
MAX_RD_STREAK, 8, consecutive read grants allowed while a write is pending before a write is forced

Ports:
mem_clock  in  1  SDRAM controller clock; all logic on rising edge
reset  in  1  synchronous, active-high
mem_ready  in  1  SDRAM init done; no grants while low
fifo_level  in  2  video FIFO fill level (3 = nearly full)
rd_req  in  1  read client request, level, held until rd_ack
rd_addr  in  ADDR_W  read address, valid with rd_req
rd_ack  out  1  one-cycle pulse: read request accepted by controller
wr_req  in  1  write client request, level, held until wr_ack
wr_addr  in  ADDR_W  write address, valid with wr_req
wr_ack  out  1  one-cycle pulse: write request accepted
wr_next  out  1  write client must present next data word next cycle
wr_done  out  1  one-cycle pulse: write burst finished
app_req  out  1  request to controller
app_req_addr  out  ADDR_W  latched address of granted client
app_req_len  out  9  RD_LEN or WR_LEN per granted type
app_req_wr_n  out  1  1 = read, 0 = write
app_req_ack  in  1  controller accepted request
app_wr_next_req  in  1  controller wants next write word
app_last_wr  in  1  controller consumed last write word
busy  out  1  state != IDLE

Behaviour:
- Reset values: state = IDLE. app_req = 0, app_req_addr = 0, app_req_len = RD_LEN, app_req_wr_n = 1. rd_ack, wr_ack, wr_next, wr_done and busy = 0. Streak counter = 0. Reset is honoured in any state and abandons an in-flight request or burst with no acks.
- States: IDLE, RD_REQ, WR_REQ, WR_DATA.
- IDLE: evaluate only when mem_ready = 1.
  - force_wr = wr_req & (streak == MAX_RD_STREAK | fifo_level == 2'b11).
  - If rd_req & !force_wr: latch rd_addr, set len = RD_LEN and wr_n = 1, go to RD_REQ.
  - Else if wr_req: latch wr_addr, set len = WR_LEN and wr_n = 0, go to WR_REQ.
  - Else stay in IDLE.
  - All of these are registered, so app_req rises one cycle after the decision.
- RD_REQ: app_req = 1. When app_req_ack = 1: rd_ack = app_req_ack combinationally in the same cycle, app_req drops the next cycle, go to IDLE. If wr_req is high at grant time, streak increments (saturating at MAX_RD_STREAK).
- WR_REQ: app_req = 1. When app_req_ack = 1: wr_ack pulses in the same cycle, streak clears, go to WR_DATA.
- WR_DATA: app_req = 0. wr_next = app_wr_next_req, passed through combinationally. When app_last_wr = 1: pulse wr_done (registered, next cycle), go to IDLE. app_wr_next_req outside WR_DATA is ignored and wr_next stays 0.
- Streak clears whenever wr_req = 0 in IDLE.
- At least one IDLE cycle separates consecutive requests. No new grant is made while a write burst is in WR_DATA.
- app_req_addr, app_req_len and app_req_wr_n remain stable from grant until the next grant.
- mem_ready dropping in IDLE blocks new grants. It does not abort RD_REQ, WR_REQ or WR_DATA.
- A requester dropping its req before ack is a protocol violation. The arbiter keeps app_req asserted regardless.

Test Plan:
- Reset, mem_ready = 0, rd_req = 1 -> app_req stays 0 for 20 cycles. Raise mem_ready -> app_req = 1 two cycles later, app_req_wr_n = 1, app_req_len = 4.
- rd_req and wr_req both high, fifo_level = 0, ack returned 3 cycles after each app_req -> the first 8 grants are reads (rd_ack pulses, app_req_addr = rd_addr), the 9th is a write, then the streak resets.
- rd_req and wr_req both high, fifo_level = 3 -> the first grant is a write: app_req_wr_n = 0, app_req_addr = wr_addr, wr_ack pulses in the app_req_ack cycle.
- Write burst, controller gives 4 app_wr_next_req pulses then app_last_wr -> exactly 4 wr_next pulses, wr_done one cycle after last_wr, no read granted before wr_done even with rd_req high.
- Reset asserted in WR_DATA after 2 next-data pulses -> next cycle all outputs at reset values, no wr_done. After release, pending rd_req is granted normally.
- app_wr_next_req pulsed during RD_REQ or IDLE -> wr_next remains 0.

Source files
------------

// File: rtl/sdram_req_arbiter_if.sv
// Request bus between the SDRAM arbiter, its two clients and the controller
// application port.
//   master : the arbiter side (drives acks, strobes and the app request)
//   slave  : the environment side (clients + controller)
// Signals: mem_ready, fifo_level, rd_req/rd_addr/rd_ack,
//          wr_req/wr_addr/wr_ack/wr_next/wr_done,
//          app_req/app_req_addr/app_req_len/app_req_wr_n/app_req_ack,
//          app_wr_next_req, app_last_wr, busy.
interface sdram_req_arbiter_if #(
  parameter int ADDR_W = 25
);
  logic              mem_ready;
  logic [1:0]        fifo_level;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              wr_next;
  logic              wr_done;
  logic              app_req;
  logic [ADDR_W-1:0] app_req_addr;
  logic [8:0]        app_req_len;
  logic              app_req_wr_n;
  logic              app_req_ack;
  logic              app_wr_next_req;
  logic              app_last_wr;
  logic              busy;

  modport master (
    input  mem_ready, fifo_level, rd_req, rd_addr, wr_req, wr_addr,
           app_req_ack, app_wr_next_req, app_last_wr,
    output rd_ack, wr_ack, wr_next, wr_done,
           app_req, app_req_addr, app_req_len, app_req_wr_n, busy
  );

  modport slave (
    output mem_ready, fifo_level, rd_req, rd_addr, wr_req, wr_addr,
           app_req_ack, app_wr_next_req, app_last_wr,
    input  rd_ack, wr_ack, wr_next, wr_done,
           app_req, app_req_addr, app_req_len, app_req_wr_n, busy
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// Two-client arbiter for the single SDRAM controller request port.
// Reads (video) win by default; a streak counter forces a pending write
// after MAX_RD_STREAK consecutive reads, and a nearly-full video FIFO
// also lets a pending write go first. Write data strobes are routed to
// the write client for the duration of the burst.
// Ports:
//   mem_clock : controller clock, all logic on rising edge
//   reset     : synchronous, active-high
//   bus       : sdram_req_arbiter_if.master (clients + controller app port)
module sdram_req_arbiter #(
  parameter int ADDR_W        = 25,
  parameter int RD_LEN        = 4,
  parameter int WR_LEN        = 4,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic                 mem_clock,
  input  logic                 reset,
  sdram_req_arbiter_if.master  bus
);
  localparam int SW = $clog2(MAX_RD_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, WR_DATA} state_t;

  state_t            state_q, state_d;
  logic              app_req_q, app_req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        len_q, len_d;
  logic              wr_n_q, wr_n_d;
  logic              wr_done_q, wr_done_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              force_wr;

  always_comb begin
    state_d   = state_q;
    app_req_d = app_req_q;
    addr_d    = addr_q;
    len_d     = len_q;
    wr_n_d    = wr_n_q;
    wr_done_d = 1'b0;
    streak_d  = streak_q;
    force_wr  = bus.wr_req & ((streak_q == STREAK_MAX) | (bus.fifo_level == 2'b11));
    case (state_q)
      IDLE: begin
        // a vanished writer ends any read streak
        if (!bus.wr_req) streak_d = '0;
        if (bus.mem_ready) begin
          if (bus.rd_req && !force_wr) begin
            addr_d    = bus.rd_addr;
            len_d     = 9'(RD_LEN);
            wr_n_d    = 1'b1;
            app_req_d = 1'b1;
            state_d   = RD_REQ;
          end else if (bus.wr_req) begin
            addr_d    = bus.wr_addr;
            len_d     = 9'(WR_LEN);
            wr_n_d    = 1'b0;
            app_req_d = 1'b1;
            state_d   = WR_REQ;
          end
        end
      end
      RD_REQ: begin
        if (bus.app_req_ack) begin
          app_req_d = 1'b0;
          state_d   = IDLE;
          // only reads that overtook a waiting write count toward the streak
          if (bus.wr_req && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end
      end
      WR_REQ: begin
        if (bus.app_req_ack) begin
          app_req_d = 1'b0;
          streak_d  = '0;
          state_d   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.app_last_wr) begin
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      app_req_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= 9'(RD_LEN);
      wr_n_q    <= 1'b1;
      wr_done_q <= 1'b0;
      streak_q  <= '0;
    end else begin
      state_q   <= state_d;
      app_req_q <= app_req_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wr_n_q    <= wr_n_d;
      wr_done_q <= wr_done_d;
      streak_q  <= streak_d;
    end
  end

  assign bus.app_req      = app_req_q;
  assign bus.app_req_addr = addr_q;
  assign bus.app_req_len  = len_q;
  assign bus.app_req_wr_n = wr_n_q;
  assign bus.wr_done      = wr_done_q;
  assign bus.busy         = (state_q != IDLE);
  // acks and data strobes are pass-through so the client sees them in the
  // same cycle the controller raises them
  assign bus.rd_ack       = (state_q == RD_REQ)  & bus.app_req_ack;
  assign bus.wr_ack       = (state_q == WR_REQ)  & bus.app_req_ack;
  assign bus.wr_next      = (state_q == WR_DATA) & bus.app_wr_next_req;
endmodule
